trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 123 ++++++++++++
 tb/tb_trap_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap / mret sequencer: captures a synchronous exception, writes CSRs for one cycle,
// then redirects the PC; a nested exception halts the core until reset.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        in_trap,
  input  logic [31:0] csr_ecall,
  input  logic [31:0] csr_mret,
  output logic [5:0]  exception_code,
  output logic [31:0] exception_mtval,
  output logic [31:0] trap_epc,
  output logic        trap_wsel,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        halt
);

  typedef enum logic [2:0] {
    IDLE,
    TRAP_WR,
    TRAP_JMP,
    MRET_WR,
    MRET_JMP,
    HALT
  } state_t;

  state_t      state;
  logic [4:0]  cause_q;
  logic [31:0] pc_q;
  logic [31:0] tval_q;

  assign trap_epc        = pc_q;
  assign exception_mtval = tval_q;

  // Control outputs are registered alongside the next state so each one is
  // valid for exactly the cycle the FSM spends in the matching state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cause_q        <= '0;
      pc_q           <= '0;
      tval_q         <= '0;
      exception_code <= '0;
      trap_wsel      <= 1'b0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      halt           <= 1'b0;
    end else begin
      exception_code <= '0;
      trap_wsel      <= 1'b0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_valid && !in_trap) begin
            cause_q        <= exc_cause;
            pc_q           <= exc_pc;
            tval_q         <= exc_tval;
            exception_code <= {1'b1, exc_cause};
            trap_wsel      <= 1'b1;
            stall          <= 1'b1;
            flush          <= 1'b1;
            state          <= TRAP_WR;
          end else if (exc_valid) begin
            halt  <= 1'b1;
            stall <= 1'b1;
            flush <= 1'b1;
            state <= HALT;
          end else if (mret_valid) begin
            exception_code <= 6'b011111;
            trap_wsel      <= 1'b1;
            stall          <= 1'b1;
            flush          <= 1'b1;
            state          <= MRET_WR;
          end
        end
        TRAP_WR: begin
          redirect_valid <= 1'b1;
          stall          <= 1'b1;
          flush          <= 1'b1;
          state          <= TRAP_JMP;
        end
        MRET_WR: begin
          redirect_valid <= 1'b1;
          stall          <= 1'b1;
          flush          <= 1'b1;
          state          <= MRET_JMP;
        end
        TRAP_JMP, MRET_JMP: begin
          state <= IDLE;
        end
        HALT: begin
          halt  <= 1'b1;
          stall <= 1'b1;
          flush <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Target follows the forwarded CSR value live during the jump cycle.
  always_comb begin
    redirect_pc = '0;
    case (state)
      TRAP_JMP: redirect_pc = csr_ecall & 32'hFFFF_FFFC;
      MRET_JMP: redirect_pc = csr_mret & 32'hFFFF_FFFE;
      default:  redirect_pc = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap, mret, priority, double fault, busy pulses, async reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        mret_valid = 1'b0;
  logic        in_trap = 1'b0;
  logic [31:0] csr_ecall = '0;
  logic [31:0] csr_mret = '0;
  logic [5:0]  exception_code;
  logic [31:0] exception_mtval;
  logic [31:0] trap_epc;
  logic        trap_wsel;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int errors = 0;
  int checks = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
    .in_trap(in_trap), .csr_ecall(csr_ecall), .csr_mret(csr_mret),
    .exception_code(exception_code), .exception_mtval(exception_mtval),
    .trap_epc(trap_epc), .trap_wsel(trap_wsel), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (exception_code !== 6'h00) begin errors++; $display("FAIL reset_code got=%h exp=00", exception_code); end
    checks++; if ({trap_wsel, stall, flush, redirect_valid, halt} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {trap_wsel, stall, flush, redirect_valid, halt}); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    checks++; if ({trap_epc, exception_mtval} !== 64'h0) begin errors++; $display("FAIL reset_capt got=%h exp=0", {trap_epc, exception_mtval}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (redirect_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b%b exp=00", redirect_valid, stall); end
  endtask

  task automatic test_trap();
    exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h0000_0100; exc_tval = 32'h0;
    csr_ecall = 32'h0000_0200; in_trap = 1'b0;
    tick();
    exc_valid = 1'b0; exc_pc = 32'h0000_0999;
    checks++; if (exception_code !== 6'h2B) begin errors++; $display("FAIL trap_code got=%h exp=2b", exception_code); end
    checks++; if (trap_epc !== 32'h100) begin errors++; $display("FAIL trap_epc got=%h exp=100", trap_epc); end
    checks++; if ({trap_wsel, stall, flush, redirect_valid} !== 4'b1110) begin errors++; $display("FAIL trap_wr_flags got=%b exp=1110", {trap_wsel, stall, flush, redirect_valid}); end
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL trap_jmp got=%b/%h exp=1/200", redirect_valid, redirect_pc); end
    checks++; if ({exception_code, trap_wsel, stall, flush} !== 9'b000000011) begin errors++; $display("FAIL trap_jmp_flags got=%b exp=000000011", {exception_code, trap_wsel, stall, flush}); end
    tick();
    checks++; if ({redirect_valid, stall, flush} !== 3'b000) begin errors++; $display("FAIL trap_done got=%b exp=000", {redirect_valid, stall, flush}); end
    checks++; if (trap_epc !== 32'h100) begin errors++; $display("FAIL trap_epc_hold got=%h exp=100", trap_epc); end
  endtask

  task automatic test_mret();
    mret_valid = 1'b1; csr_mret = 32'h0000_0104;
    tick();
    mret_valid = 1'b0;
    checks++; if (exception_code !== 6'h1F || trap_wsel !== 1'b1) begin errors++; $display("FAIL mret_wr got=%h/%b exp=1f/1", exception_code, trap_wsel); end
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin errors++; $display("FAIL mret_jmp got=%b/%h exp=1/104", redirect_valid, redirect_pc); end
    csr_mret = 32'h0000_0105;
    #1;
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL mret_lsb got=%h exp=104", redirect_pc); end
    tick();
    checks++; if ({redirect_valid, stall, exception_code} !== 8'h0) begin errors++; $display("FAIL mret_idle got=%b%b/%h exp=00/00", redirect_valid, stall, exception_code); end
    // Back in IDLE: a fresh mret must be accepted immediately.
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    checks++; if (exception_code !== 6'h1F) begin errors++; $display("FAIL mret_again got=%h exp=1f", exception_code); end
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    int seen1f = 0;
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD_BEEF; exc_pc = 32'h0000_0040;
    tick();
    exc_valid = 1'b0; mret_valid = 1'b0;
    checks++; if (exception_code !== 6'h22) begin errors++; $display("FAIL simul_code got=%h exp=22", exception_code); end
    checks++; if (exception_mtval !== 32'hDEAD_BEEF) begin errors++; $display("FAIL simul_mtval got=%h exp=deadbeef", exception_mtval); end
    for (int i = 0; i < 4; i++) begin
      if (exception_code === 6'h1F) seen1f++;
      tick();
    end
    checks++; if (seen1f !== 0) begin errors++; $display("FAIL simul_no_mret got=%0d exp=0", seen1f); end
  endtask

  task automatic test_back_to_back();
    int rv = 0;
    csr_ecall = 32'h0000_0203; exc_cause = 5'd3; exc_pc = 32'h0000_0300;
    exc_valid = 1'b1;
    tick();
    exc_pc = 32'h0000_0500; exc_cause = 5'd7;
    tick();
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL busy_mask got=%h exp=200", redirect_pc); end
    if (redirect_valid === 1'b1) rv++;
    tick();
    exc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (redirect_valid === 1'b1) rv++;
      tick();
    end
    checks++; if (rv !== 1) begin errors++; $display("FAIL busy_redirects got=%0d exp=1", rv); end
    checks++; if (trap_epc !== 32'h300) begin errors++; $display("FAIL busy_epc got=%h exp=300", trap_epc); end
  endtask

  task automatic test_double_fault();
    int bad = 0;
    in_trap = 1'b1; exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0;
    checks++; if ({halt, stall, flush, redirect_valid, exception_code} !== 10'b1110_000000) begin errors++; $display("FAIL dfault_enter got=%b exp=1110000000", {halt, stall, flush, redirect_valid, exception_code}); end
    in_trap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exc_valid = (i % 2 == 0); mret_valid = (i % 2 == 1);
      tick();
      if (halt !== 1'b1 || redirect_valid !== 1'b0 || exception_code !== 6'h0) bad++;
    end
    exc_valid = 1'b0; mret_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL dfault_sticky got=%0d exp=0", bad); end
    #2 rst = 1'b1;
    #1;
    checks++; if (halt !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL dfault_clear got=%b%b exp=00", halt, stall); end
    tick();
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int rv = 0;
    exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h0000_0700; exc_tval = 32'h1234_5678;
    tick();
    exc_valid = 1'b0;
    checks++; if (exception_code !== 6'h2B) begin errors++; $display("FAIL rmid_pre got=%h exp=2b", exception_code); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({exception_code, trap_wsel, stall, flush, redirect_valid, halt} !== 11'b0) begin errors++; $display("FAIL rmid_flags got=%b exp=0", {exception_code, trap_wsel, stall, flush, redirect_valid, halt}); end
    checks++; if ({trap_epc, exception_mtval, redirect_pc} !== 96'h0) begin errors++; $display("FAIL rmid_data got=%h exp=0", {trap_epc, exception_mtval, redirect_pc}); end
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (redirect_valid !== 1'b0 || stall !== 1'b0) rv++;
    end
    checks++; if (rv !== 0) begin errors++; $display("FAIL rmid_quiet got=%0d exp=0", rv); end
  endtask

  initial begin
    test_reset();
    test_trap();
    test_mret();
    test_simultaneous();
    test_back_to_back();
    test_double_fault();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
